resp_misr_checker: RTL
======================

RESP_MISR_CHECKER -- requirements
Module: resp_misr_checker

Interface
REQ-001 Parameter Y_W, default 246, SHALL set the width of the DUT response word.
REQ-002 Parameter SIG_W, default 32, SHALL set the signature width.
REQ-003 Parameter CNT_W, default 16, SHALL set the sample-count width.
REQ-004 Parameter POLY, default 32'h04C11DB7, SHALL be the MISR feedback polynomial.
REQ-005 Parameter SEED, default 32'hFFFFFFFF, SHALL be the MISR start value.
REQ-006 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-007 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-008 start  input  1  SHALL request a new capture run.
REQ-009 abort  input  1  SHALL cancel a run in progress.
REQ-010 num_cycles  input  CNT_W  SHALL give the number of samples to compact; it SHALL be latched on an accepted start.
REQ-011 exp_sig  input  SIG_W  SHALL give the expected signature; it SHALL be latched on an accepted start.
REQ-012 y  input  Y_W  SHALL carry the DUT response word.
REQ-013 y_valid  input  1  SHALL qualify y for one sample per high cycle.
REQ-014 busy  output  1  SHALL be high while in state RUN.
REQ-015 done  output  1  SHALL be high while in state DONE.
REQ-016 pass  output  1  SHALL indicate a signature match; it SHALL be valid only while done is high.
REQ-017 signature  output  SIG_W  SHALL carry the current MISR value.
REQ-018 sample_cnt  output  CNT_W  SHALL count the samples accepted in the current run.

Function
REQ-019 The FSM SHALL have the states IDLE, RUN and DONE, all registered.
REQ-020 In IDLE or DONE, start=1 SHALL load signature=SEED and sample_cnt=0 and latch num_cycles and exp_sig; the next state SHALL be RUN, or DONE if num_cycles==0.
REQ-021 In RUN, start SHALL be ignored.
REQ-022 In RUN, a cycle with y_valid=1 SHALL be a sample; y_valid=0 cycles SHALL hold all state.
REQ-023 y SHALL be zero-padded to ceil(Y_W/SIG_W)*SIG_W bits, and fold(y) SHALL be the XOR of all SIG_W-bit slices.
REQ-024 Per sample: sig_next = {sig[SIG_W-2:0],0} ^ (sig[SIG_W-1] ? POLY : 0) ^ fold(y), and sample_cnt SHALL be incremented by 1.
REQ-025 When a sample makes sample_cnt+1 equal the latched num_cycles, the next state SHALL be DONE, with done high in the cycle after that sample (latency 1).
REQ-026 pass SHALL be registered as (final signature == latched exp_sig) on entry to DONE.
REQ-027 In DONE, signature, sample_cnt and pass SHALL hold until the next accepted start.
REQ-028 y_valid outside RUN SHALL be ignored.
REQ-029 abort=1 in RUN SHALL return the block to IDLE next cycle with done=0 and pass=0, and signature and sample_cnt SHALL hold.
REQ-030 abort SHALL have priority over a same-cycle final sample.
REQ-031 abort outside RUN SHALL be ignored.
REQ-032 start and abort together in IDLE or DONE SHALL act as start.
REQ-033 sample_cnt SHALL NOT wrap, because the run ends at num_cycles <= 2^CNT_W-1.

Reset
REQ-034 While rst_n=0, the block SHALL be in state IDLE with busy=0, done=0, pass=0, signature=SEED, sample_cnt=0, and latched num_cycles and exp_sig = 0.
REQ-035 Reset asserted mid-RUN SHALL take effect immediately (asynchronous), and no partial signature SHALL be retained.
REQ-036 After rst_n deasserts, the block SHALL stay in IDLE until start.

Verification
REQ-037 start, num_cycles=0, exp_sig=32'hFFFFFFFF -> done=1 the next cycle, signature=FFFFFFFF, pass=1, busy never high.
REQ-038 start, num_cycles=1, then y=0 with y_valid=1 -> signature=32'hFB3EE249 and sample_cnt=1; with exp_sig=FB3EE249 -> pass=1, and with exp_sig=0 -> pass=0.
REQ-039 num_cycles=4 with y_valid pattern 1,0,0,1,1,0,1 -> done exactly one cycle after the 4th valid, and the signature matches the reference model of REQ-023/REQ-024.
REQ-040 Run with num_cycles=8, assert start after 3 samples -> ignored, sample_cnt continues to 8, done as normal.
REQ-041 abort after 2 of 5 samples -> IDLE, done=0, sample_cnt=2; a following start -> sample_cnt=0, signature=SEED.
REQ-042 rst_n pulsed low mid-RUN -> outputs take their REQ-034 values within the same cycle, before the next clock edge.

Source files
------------

// File: rtl/resp_misr_checker.sv
// resp_misr_checker
// Compacts a stream of DUT response words into a MISR signature and, at the
// end of a run of num_cycles samples, compares it against an expected value.
//
// Ports:
//   clk, rst_n   - clock (rising edge) and asynchronous active-low reset
//   start        - begin a new capture run (accepted in IDLE or DONE)
//   abort        - cancel the run in progress (RUN only)
//   num_cycles   - number of samples to compact, latched on accepted start
//   exp_sig      - expected signature, latched on accepted start
//   y, y_valid   - response word and its per-cycle qualifier
//   busy, done   - high in RUN / DONE respectively
//   pass         - signature matched exp_sig (meaningful while done is high)
//   signature    - current MISR contents
//   sample_cnt   - samples accepted in the current run
module resp_misr_checker #(
  parameter int               Y_W   = 246,
  parameter int               SIG_W = 32,
  parameter int               CNT_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED  = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_cycles,
  input  logic [SIG_W-1:0] exp_sig,
  input  logic [Y_W-1:0]   y,
  input  logic             y_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] sample_cnt
);

  // The response word is zero-padded up to a whole number of signature slices.
  localparam int N_SLICE = (Y_W + SIG_W - 1) / SIG_W;
  localparam int PAD_W   = N_SLICE * SIG_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] num_lat;
  logic [SIG_W-1:0] exp_lat;
  logic [SIG_W-1:0] sig_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             final_sample;

  // XOR of all SIG_W-bit slices of the zero-padded response word.
  function automatic logic [SIG_W-1:0] fold(input logic [Y_W-1:0] v);
    logic [PAD_W-1:0] padded;
    logic [SIG_W-1:0] acc;
    padded = PAD_W'(v);
    acc    = {SIG_W{1'b0}};
    for (int i = 0; i < N_SLICE; i++) begin
      acc = acc ^ padded[i*SIG_W +: SIG_W];
    end
    return acc;
  endfunction

  // One MISR shift: multiply by x modulo POLY, then inject the folded data.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                 input logic [SIG_W-1:0] data);
    return {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : {SIG_W{1'b0}}) ^ data;
  endfunction

  // Next signature / count for a sample taken this cycle.
  always_comb begin
    sig_next     = misr_step(signature, fold(y));
    cnt_inc      = sample_cnt + CNT_W'(1'b1);
    final_sample = (cnt_inc == num_lat);
  end

  // Control FSM with registered status outputs and the MISR datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      signature  <= SEED;
      sample_cnt <= {CNT_W{1'b0}};
      num_lat    <= {CNT_W{1'b0}};
      exp_lat    <= {SIG_W{1'b0}};
    end else begin
      case (state)
        IDLE, DONE: begin
          // start wins over a simultaneous abort; abort/y_valid are otherwise ignored here.
          if (start) begin
            signature  <= SEED;
            sample_cnt <= {CNT_W{1'b0}};
            num_lat    <= num_cycles;
            exp_lat    <= exp_sig;
            if (num_cycles == {CNT_W{1'b0}}) begin
              // Empty run: the seed itself is the final signature.
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (SEED == exp_sig);
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end
          end else begin
            state <= state;
          end
        end
        RUN: begin
          // abort outranks a final sample in the same cycle; data registers hold.
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
          end else if (y_valid) begin
            signature  <= sig_next;
            sample_cnt <= cnt_inc;
            if (final_sample) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (sig_next == exp_lat);
            end else begin
              state <= RUN;
            end
          end else begin
            state <= RUN;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule
